up_down_counter_mod: RTL and testbench

//   Parametrised N-bit counter for general timing/sequencing use in the design.

---
 rtl/up_down_counter_mod.sv | 79 +++++++
 tb/tb_up_down_counter_mod.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod: N-bit up/down counter with clock enable, synchronous
// parallel load, runtime terminal value (0..max_val), wrap or saturate mode,
// a registered terminal-count pulse and a sticky overflow flag.
module up_down_counter_mod #(
  parameter int N    = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_down,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  input  logic         clr_ovf,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         ovf
);

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         boundary;

  // Next-state: load beats counting; a boundary event is reaching the end of
  // the range in the counting direction (or sitting at it in saturate mode).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    q_d      = q_q;
    boundary = 1'b0;
    if (load) begin
      q_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (up_down) begin
        if (q_q >= max_val) begin
          boundary = 1'b1;
          q_d      = WRAP ? '0 : max_val;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q > max_val) begin
          // Only reachable after max_val was lowered; pull back into range.
          q_d = max_val;
        end else if (q_q == '0) begin
          boundary = 1'b1;
          q_d      = WRAP ? max_val : '0;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
    tc_d  = boundary;
    // A boundary event on the same edge as clr_ovf keeps the flag set.
    ovf_d = boundary | (ovf_q & ~clr_ovf);
  end

  // State registers with synchronous active-high reset overriding everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Testbench for up_down_counter_mod: directed scenarios against hand-derived
// values on a wrapping and a saturating instance, then randomized stimulus
// against a behavioural model of the counting rules.
module tb_up_down_counter_mod;

  logic       clk = 1'b0;
  logic       reset, en, up_down, load, clr_ovf;
  logic [7:0] load_val, max_val;
  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  up_down_counter_mod #(.N(8), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .Q(q_w), .tc(tc_w), .ovf(ovf_w)
  );

  up_down_counter_mod #(.N(8), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .Q(q_s), .tc(tc_s), .ovf(ovf_s)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit e, input bit ud, input bit ld,
                       input int lv, input int mv, input bit co);
    reset = r; en = e; up_down = ud; load = ld;
    load_val = lv[7:0]; max_val = mv[7:0]; clr_ovf = co;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 77, 200, 0);
    tick();
    n_cmp += 2;
    if ({q_w, tc_w, ovf_w} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_w: got Q=%0d tc=%0b ovf=%0b, want 0 0 0", q_w, tc_w, ovf_w);
    end
    if ({q_s, tc_s, ovf_s} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_s: got Q=%0d tc=%0b ovf=%0b, want 0 0 0", q_s, tc_s, ovf_s);
    end
  endtask

  task automatic test_wrap_up();
    drive(1, 0, 1, 0, 0, 9, 0);
    tick();
    drive(0, 1, 1, 0, 0, 9, 0);
    for (int i = 1; i <= 25; i++) begin
      int  eq;
      bit  etc, eovf;
      tick();
      eq = i % 10; etc = (eq == 0); eovf = (i >= 10);
      n_cmp++;
      if (q_w !== eq[7:0] || tc_w !== etc || ovf_w !== eovf) begin
        n_err++;
        $display("FAIL wrap_up[%0d]: got Q=%0d tc=%0b ovf=%0b, want Q=%0d tc=%0b ovf=%0b",
                 i, q_w, tc_w, ovf_w, eq, etc, eovf);
      end
    end
  endtask

  task automatic test_down_wrap();
    int eq[4]  = '{1, 0, 5, 4};
    bit etc[4] = '{0, 0, 1, 0};
    drive(0, 0, 0, 1, 2, 5, 0);
    tick();
    drive(0, 1, 0, 0, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (q_w !== eq[i][7:0] || tc_w !== etc[i] || ovf_w !== 1'b1) begin
        n_err++;
        $display("FAIL down_wrap[%0d]: got Q=%0d tc=%0b ovf=%0b, want Q=%0d tc=%0b ovf=1",
                 i, q_w, tc_w, ovf_w, eq[i], etc[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 5, 1);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== {8'd4, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL clr_ovf: got Q=%0d tc=%0b ovf=%0b, want Q=4 tc=0 ovf=0", q_w, tc_w, ovf_w);
    end
  endtask

  task automatic test_saturate();
    int eq[6] = '{1, 2, 3, 3, 3, 3};
    drive(1, 0, 1, 0, 0, 3, 0);
    tick();
    drive(0, 1, 1, 0, 0, 3, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (q_s !== eq[i][7:0] || tc_s !== (i >= 3) || ovf_s !== (i >= 3)) begin
        n_err++;
        $display("FAIL saturate[%0d]: got Q=%0d tc=%0b ovf=%0b, want Q=%0d tc=%0b ovf=%0b",
                 i, q_s, tc_s, ovf_s, eq[i], (i >= 3), (i >= 3));
      end
    end
  endtask

  task automatic test_load();
    drive(0, 1, 1, 1, 200, 100, 0);
    tick();
    n_cmp += 2;
    if (q_w !== 8'd100 || tc_w !== 1'b0) begin
      n_err++;
      $display("FAIL load_clamp_w: got Q=%0d tc=%0b, want Q=100 tc=0", q_w, tc_w);
    end
    if (q_s !== 8'd100 || tc_s !== 1'b0) begin
      n_err++;
      $display("FAIL load_clamp_s: got Q=%0d tc=%0b, want Q=100 tc=0", q_s, tc_s);
    end
    drive(0, 1, 1, 1, 7, 100, 0);
    tick();
    n_cmp++;
    if (q_w !== 8'd7 || tc_w !== 1'b0) begin
      n_err++;
      $display("FAIL load_no_count: got Q=%0d tc=%0b, want Q=7 tc=0", q_w, tc_w);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 1, 50, 100, 0);
    tick();
    drive(0, 1, 1, 0, 0, 100, 0);
    tick();
    n_cmp++;
    if (q_w !== 8'd51) begin
      n_err++;
      $display("FAIL pre_reset_count: got Q=%0d, want 51", q_w);
    end
    drive(1, 1, 1, 1, 9, 100, 0);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_mid: got Q=%0d tc=%0b ovf=%0b, want 0 0 0", q_w, tc_w, ovf_w);
    end
    drive(0, 1, 1, 0, 0, 100, 0);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== {8'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL resume_after_reset: got Q=%0d tc=%0b ovf=%0b, want 1 0 0", q_w, tc_w, ovf_w);
    end
  endtask

  task automatic test_lower_max();
    drive(0, 0, 1, 1, 8, 100, 1);
    tick();
    drive(0, 1, 0, 0, 0, 4, 0);
    tick();
    n_cmp += 2;
    if ({q_w, tc_w, ovf_w} !== {8'd4, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL lower_max_down_w: got Q=%0d tc=%0b ovf=%0b, want 4 0 0", q_w, tc_w, ovf_w);
    end
    if ({q_s, tc_s, ovf_s} !== {8'd4, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL lower_max_down_s: got Q=%0d tc=%0b ovf=%0b, want 4 0 0", q_s, tc_s, ovf_s);
    end
    drive(0, 1, 1, 0, 0, 4, 0);
    tick();
    n_cmp += 2;
    if ({q_w, tc_w, ovf_w} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL lower_max_up_w: got Q=%0d tc=%0b ovf=%0b, want 0 1 1", q_w, tc_w, ovf_w);
    end
    if ({q_s, tc_s, ovf_s} !== {8'd4, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL lower_max_up_s: got Q=%0d tc=%0b ovf=%0b, want 4 1 1", q_s, tc_s, ovf_s);
    end
  endtask

  task automatic test_full_range();
    drive(0, 0, 1, 1, 255, 255, 1);
    tick();
    drive(0, 1, 1, 0, 0, 255, 0);
    tick();
    n_cmp += 2;
    if (q_w !== 8'd0 || tc_w !== 1'b1) begin
      n_err++;
      $display("FAIL full_up_wrap: got Q=%0d tc=%0b, want Q=0 tc=1", q_w, tc_w);
    end
    if (q_s !== 8'd255 || tc_s !== 1'b1) begin
      n_err++;
      $display("FAIL full_up_sat: got Q=%0d tc=%0b, want Q=255 tc=1", q_s, tc_s);
    end
    drive(0, 1, 0, 0, 0, 255, 0);
    tick();
    n_cmp += 2;
    if (q_w !== 8'd255 || tc_w !== 1'b1) begin
      n_err++;
      $display("FAIL full_down_wrap: got Q=%0d tc=%0b, want Q=255 tc=1", q_w, tc_w);
    end
    if (q_s !== 8'd254 || tc_s !== 1'b0) begin
      n_err++;
      $display("FAIL full_down_sat: got Q=%0d tc=%0b, want Q=254 tc=0", q_s, tc_s);
    end
  endtask

  task automatic test_max_zero();
    drive(0, 0, 1, 1, 5, 0, 1);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== 10'd0) begin
      n_err++;
      $display("FAIL max0_load: got Q=%0d tc=%0b ovf=%0b, want 0 0 0", q_w, tc_w, ovf_w);
    end
    // Boundary and clr_ovf on the same edge: set must win.
    drive(0, 1, 1, 0, 0, 0, 1);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL max0_up_set_wins: got Q=%0d tc=%0b ovf=%0b, want 0 1 1", q_w, tc_w, ovf_w);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if ({q_s, tc_s, ovf_s} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL max0_down_s: got Q=%0d tc=%0b ovf=%0b, want 0 1 1", q_s, tc_s, ovf_s);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++;
    if ({q_w, tc_w, ovf_w} !== 10'd0) begin
      n_err++;
      $display("FAIL max0_idle_clr: got Q=%0d tc=%0b ovf=%0b, want 0 0 0", q_w, tc_w, ovf_w);
    end
  endtask

  // Behavioural rule set: where the count goes next and whether that step is
  // a boundary event, written directly from the counting rules.
  function automatic void model_step(input bit wrap, input int q, output int nq, output bit hit);
    int top;
    top = int'(max_val);
    hit = 1'b0;
    nq  = q;
    if (reset)     nq = 0;
    else if (load) nq = (int'(load_val) < top) ? int'(load_val) : top;
    else if (en && up_down) begin
      if (q < top) nq = q + 1;
      else begin hit = 1'b1; nq = wrap ? 0 : top; end
    end else if (en) begin
      if (q > top)       nq = top;
      else if (q == 0) begin hit = 1'b1; nq = wrap ? top : 0; end
      else               nq = q - 1;
    end
  endfunction

  task automatic test_random();
    int mq[2]   = '{0, 0};
    bit mtc[2]  = '{0, 0};
    bit movf[2] = '{0, 0};
    int mv = 20;
    drive(1, 0, 0, 0, 0, mv, 0);
    tick();
    for (int c = 0; c < 800; c++) begin
      int nq;
      bit hit;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: mv = 0;
          1: mv = 255;
          2: mv = $urandom_range(1, 12);
          default: mv = $urandom_range(0, 255);
        endcase
      end
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 255), mv,
            $urandom_range(0, 7) == 0);
      for (int k = 0; k < 2; k++) begin
        model_step(k == 0, mq[k], nq, hit);
        mq[k]   = nq;
        mtc[k]  = hit && !reset;
        movf[k] = !reset && (hit || (movf[k] && !clr_ovf));
      end
      tick();
      n_cmp += 2;
      if (q_w !== mq[0][7:0] || tc_w !== mtc[0] || ovf_w !== movf[0]) begin
        n_err++;
        $display("FAIL random_w[%0d]: got Q=%0d tc=%0b ovf=%0b, want Q=%0d tc=%0b ovf=%0b",
                 c, q_w, tc_w, ovf_w, mq[0], mtc[0], movf[0]);
      end
      if (q_s !== mq[1][7:0] || tc_s !== mtc[1] || ovf_s !== movf[1]) begin
        n_err++;
        $display("FAIL random_s[%0d]: got Q=%0d tc=%0b ovf=%0b, want Q=%0d tc=%0b ovf=%0b",
                 c, q_s, tc_s, ovf_s, mq[1], mtc[1], movf[1]);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_wrap_up();
    test_down_wrap();
    test_saturate();
    test_load();
    test_reset_mid();
    test_lower_max();
    test_full_range();
    test_max_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
